// File: rtl/seq_det_pkg.sv
// Shared types and width helpers for the programmable lamp sequence detector.
package seq_det_pkg;

    // Per-cycle view of the lamp bus: nothing lit, exactly one lit, or several lit.
    typedef enum logic [1:0] {
        LampIdle,
        LampEvent,
        LampMulti
    } lamp_class_e;

    function automatic int unsigned idx_width(input int unsigned n_lamps);
        return (n_lamps > 1) ? $clog2(n_lamps) : 1;
    endfunction

    function automatic int unsigned pos_width(input int unsigned max_len);
        return $clog2(max_len + 1);
    endfunction

    // Power-up sequence is lamp0 -> lamp1 -> lamp2 (wrapping on narrow builds).
    function automatic int unsigned default_len(input int unsigned max_len);
        return (max_len < 3) ? max_len : 3;
    endfunction

    function automatic int unsigned default_idx(input int unsigned i, input int unsigned n_lamps);
        return i % n_lamps;
    endfunction

endpackage

// File: rtl/seq_det_alarm_stretch.sv
// Stretches a single-cycle detect pulse into an ALARM_HOLD-cycle alarm and keeps a
// saturating count of detections.
module seq_det_alarm_stretch #(
    parameter int unsigned ALARM_HOLD = 1,
    parameter int unsigned CNT_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             detect,
    output logic             alarm,
    output logic [CNT_W-1:0] det_cnt
);

    localparam int unsigned HOLD_W = $clog2(ALARM_HOLD + 1);

    logic [HOLD_W-1:0] hold_q;
    logic [CNT_W-1:0]  cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_q <= '0;
            cnt_q  <= '0;
        end else if (detect) begin
            // A detection inside an active hold restarts the full hold window.
            hold_q <= HOLD_W'(ALARM_HOLD);
            if (cnt_q != '1) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end else if (hold_q != '0) begin
            hold_q <= hold_q - HOLD_W'(1);
        end
    end

    assign alarm   = (hold_q != '0);
    assign det_cnt = cnt_q;

endmodule

// File: rtl/seq_detector_param.sv
// Programmable lamp sequence detector with idle-tolerant matching and stretched alarm.
// Define SEQ_DET_TIMEOUT_EN to abandon progress after TIMEOUT consecutive idle cycles.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int unsigned N_LAMPS    = 3,
    parameter int unsigned MAX_LEN    = 4,
    parameter int unsigned ALARM_HOLD = 1,
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned TIMEOUT    = 15,
    localparam int unsigned IDX_W     = idx_width(N_LAMPS),
    localparam int unsigned POS_W     = pos_width(MAX_LEN)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_LAMPS-1:0]       lamp,
    input  logic                     cfg_we,
    input  logic [MAX_LEN*IDX_W-1:0] cfg_seq,
    input  logic [POS_W-1:0]         cfg_len,
    output logic [POS_W-1:0]         pos,
    output logic                     alarm,
    output logic [CNT_W-1:0]         det_cnt,
    output logic                     cfg_err
);

    logic [IDX_W-1:0] seq_q [MAX_LEN];
    logic [POS_W-1:0] len_q;
    logic [POS_W-1:0] pos_q;
    logic [POS_W-1:0] pos_d;
    logic             cfg_err_q;

    lamp_class_e      lamp_cls;
    logic [IDX_W-1:0] lamp_idx;
    int unsigned      ones;
    logic [IDX_W-1:0] cur_idx;
    logic [IDX_W-1:0] cfg_elem [MAX_LEN];
    logic             cfg_ok;
    logic             detect;
    logic             timeout_hit;

    always_comb begin
        ones     = 0;
        lamp_idx = '0;
        for (int i = 0; i < N_LAMPS; i++) begin
            if (lamp[i]) begin
                ones     = ones + 1;
                lamp_idx = IDX_W'(i);
            end
        end
        if (ones == 0) begin
            lamp_cls = LampIdle;
        end else if (ones == 1) begin
            lamp_cls = LampEvent;
        end else begin
            lamp_cls = LampMulti;
        end
    end

    always_comb begin
        cur_idx = seq_q[0];
        for (int i = 0; i < MAX_LEN; i++) begin
            if (pos_q == POS_W'(i)) begin
                cur_idx = seq_q[i];
            end
        end
    end

    // Only elements inside the requested length are range-checked.
    always_comb begin
        cfg_ok = (cfg_len >= POS_W'(2)) && (cfg_len <= POS_W'(MAX_LEN));
        for (int i = 0; i < MAX_LEN; i++) begin
            cfg_elem[i] = cfg_seq[i*IDX_W +: IDX_W];
            if ((POS_W'(i) < cfg_len) && (32'(cfg_elem[i]) >= N_LAMPS)) begin
                cfg_ok = 1'b0;
            end
        end
    end

`ifdef SEQ_DET_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

    logic [TO_W-1:0] idle_q;
    logic [TO_W-1:0] idle_d;

    always_comb begin
        idle_d      = '0;
        timeout_hit = 1'b0;
        if (!cfg_we && (lamp_cls == LampIdle) && (pos_q != '0)) begin
            if (idle_q == TO_W'(TIMEOUT - 1)) begin
                timeout_hit = 1'b1;
            end else begin
                idle_d = idle_q + TO_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign timeout_hit    = 1'b0;
`endif

    // Mismatch only falls back to the first element; deeper overlaps are not tracked.
    always_comb begin
        pos_d  = pos_q;
        detect = 1'b0;
        case (lamp_cls)
            LampIdle: begin
                if (timeout_hit) begin
                    pos_d = '0;
                end
            end
            LampEvent: begin
                if (lamp_idx == cur_idx) begin
                    if (pos_q == len_q - POS_W'(1)) begin
                        detect = 1'b1;
                        pos_d  = '0;
                    end else begin
                        pos_d = pos_q + POS_W'(1);
                    end
                end else if (lamp_idx == seq_q[0]) begin
                    pos_d = POS_W'(1);
                end else begin
                    pos_d = '0;
                end
            end
            default: pos_d = '0;
        endcase
        if (cfg_we) begin
            detect = 1'b0;
            pos_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                seq_q[i] <= IDX_W'(default_idx(i, N_LAMPS));
            end
            len_q     <= POS_W'(default_len(MAX_LEN));
            pos_q     <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            pos_q <= pos_d;
            if (cfg_we) begin
                cfg_err_q <= !cfg_ok;
                if (cfg_ok) begin
                    seq_q <= cfg_elem;
                    len_q <= cfg_len;
                end
            end
        end
    end

    seq_det_alarm_stretch #(
        .ALARM_HOLD (ALARM_HOLD),
        .CNT_W      (CNT_W)
    ) u_stretch (
        .clk     (clk),
        .reset   (reset),
        .detect  (detect),
        .alarm   (alarm),
        .det_cnt (det_cnt)
    );

    assign pos     = pos_q;
    assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: a vector table, hand-built corner sequences and random
// traffic against a behavioural model; follows SEQ_DET_TIMEOUT_EN like the design.
module tb_seq_detector_param;

    localparam int TO = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] lamp = '0;
    logic       cfg_we = 1'b0;
    logic [7:0] cfg_seq = '0;
    logic [2:0] cfg_len = '0;

    logic [2:0] pos_a, pos_b;
    logic       alarm_a, alarm_b;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;
    logic       err_a, err_b;

    always #5 clk = ~clk;

    seq_detector_param #(
        .N_LAMPS(3), .MAX_LEN(4), .ALARM_HOLD(1), .CNT_W(8), .TIMEOUT(TO)
    ) dut_a (
        .clk(clk), .reset(reset), .lamp(lamp), .cfg_we(cfg_we), .cfg_seq(cfg_seq),
        .cfg_len(cfg_len), .pos(pos_a), .alarm(alarm_a), .det_cnt(cnt_a), .cfg_err(err_a)
    );

    seq_detector_param #(
        .N_LAMPS(3), .MAX_LEN(4), .ALARM_HOLD(4), .CNT_W(2), .TIMEOUT(TO)
    ) dut_b (
        .clk(clk), .reset(reset), .lamp(lamp), .cfg_we(cfg_we), .cfg_seq(cfg_seq),
        .cfg_len(cfg_len), .pos(pos_b), .alarm(alarm_b), .det_cnt(cnt_b), .cfg_err(err_b)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic cmp(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: sequence as int array, alarm from time since last detection.
    int m_seq[4];
    int m_len, m_pos, m_err, m_cnt, m_idle, m_cyc, m_det_cyc;
    bit m_det_valid;

    task automatic model_edge(input bit r, input logic [2:0] l, input bit w,
                              input logic [7:0] s, input logic [2:0] n);
        int ones;
        int k;
        bit ok;
        m_cyc++;
        if (r) begin
            for (int i = 0; i < 4; i++) m_seq[i] = i % 3;
            m_len = 3; m_pos = 0; m_err = 0; m_cnt = 0; m_idle = 0; m_det_valid = 0;
            return;
        end
        if (w) begin
            ok = (n >= 2) && (n <= 4);
            for (int i = 0; i < 4; i++)
                if (i < int'(n) && int'(s[2*i +: 2]) >= 3) ok = 0;
            if (ok) begin
                for (int i = 0; i < 4; i++) m_seq[i] = int'(s[2*i +: 2]);
                m_len = int'(n);
            end
            m_err = ok ? 0 : 1;
            m_pos = 0;
            m_idle = 0;
            return;
        end
        ones = $countones(l);
        if (ones == 0) begin
`ifdef SEQ_DET_TIMEOUT_EN
            if (m_pos != 0) begin
                m_idle++;
                if (m_idle >= TO) begin
                    m_pos = 0;
                    m_idle = 0;
                end
            end else begin
                m_idle = 0;
            end
`endif
        end else begin
            m_idle = 0;
            if (ones > 1) begin
                m_pos = 0;
            end else begin
                k = l[1] ? 1 : (l[2] ? 2 : 0);
                if (k == m_seq[m_pos]) begin
                    if (m_pos == m_len - 1) begin
                        m_pos = 0;
                        m_cnt++;
                        m_det_valid = 1;
                        m_det_cyc = m_cyc;
                    end else begin
                        m_pos++;
                    end
                end else begin
                    m_pos = (k == m_seq[0]) ? 1 : 0;
                end
            end
        end
    endtask

    task automatic check_model();
        cmp("pos_a", int'(pos_a), m_pos);
        cmp("pos_b", int'(pos_b), m_pos);
        cmp("alarm_a", int'(alarm_a), (m_det_valid && (m_cyc - m_det_cyc) < 1) ? 1 : 0);
        cmp("alarm_b", int'(alarm_b), (m_det_valid && (m_cyc - m_det_cyc) < 4) ? 1 : 0);
        cmp("det_cnt_a", int'(cnt_a), (m_cnt > 255) ? 255 : m_cnt);
        cmp("det_cnt_b", int'(cnt_b), (m_cnt > 3) ? 3 : m_cnt);
        cmp("cfg_err_a", int'(err_a), m_err);
        cmp("cfg_err_b", int'(err_b), m_err);
    endtask

    task automatic step(input bit r, input logic [2:0] l, input bit w,
                        input logic [7:0] s, input logic [2:0] n);
        reset = r; lamp = l; cfg_we = w; cfg_seq = s; cfg_len = n;
        @(posedge clk);
        model_edge(r, l, w, s, n);
        #1;
        check_model();
    endtask

    task automatic ev(input logic [2:0] l);
        step(1'b0, l, 1'b0, 8'h00, 3'd0);
    endtask

    typedef struct {
        bit         r;
        logic [2:0] l;
        bit         w;
        logic [7:0] s;
        logic [2:0] n;
        int         pos;
        int         al;
        int         cnt;
        int         err;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(bit r, logic [2:0] l, bit w, logic [7:0] s, logic [2:0] n,
                                int p, int a, int c, int e);
        vec_t v;
        v.r = r; v.l = l; v.w = w; v.s = s; v.n = n;
        v.pos = p; v.al = a; v.cnt = c; v.err = e;
        return v;
    endfunction

`ifdef SEQ_DET_TIMEOUT_EN
    localparam int IDLE_POS = 0, IDLE_AL = 0, IDLE_CNT = 0;
`else
    localparam int IDLE_POS = 1, IDLE_AL = 1, IDLE_CNT = 1;
`endif

    initial begin
        logic [2:0] rl;
        logic [7:0] rs;
        logic [2:0] rn;
        int         c;

        // Sequence 2,2,0,1 packs as 0x4A; 2,3,0,1 as 0x4E; 0,1,x,3 as 0xC4.
        vt.push_back(mk(1, 3'b000, 0, 8'h00, 3'd0, 0, 0, 0, 0));
        vt.push_back(mk(0, 3'b001, 0, 8'h00, 3'd0, 1, 0, 0, 0));
        vt.push_back(mk(0, 3'b010, 0, 8'h00, 3'd0, 2, 0, 0, 0));
        vt.push_back(mk(0, 3'b100, 0, 8'h00, 3'd0, 0, 1, 1, 0));
        vt.push_back(mk(0, 3'b000, 0, 8'h00, 3'd0, 0, 0, 1, 0));
        vt.push_back(mk(0, 3'b001, 0, 8'h00, 3'd0, 1, 0, 1, 0));
        vt.push_back(mk(0, 3'b010, 0, 8'h00, 3'd0, 2, 0, 1, 0));
        vt.push_back(mk(0, 3'b001, 0, 8'h00, 3'd0, 1, 0, 1, 0));
        vt.push_back(mk(0, 3'b010, 0, 8'h00, 3'd0, 2, 0, 1, 0));
        vt.push_back(mk(0, 3'b100, 0, 8'h00, 3'd0, 0, 1, 2, 0));
        vt.push_back(mk(0, 3'b001, 0, 8'h00, 3'd0, 1, 0, 2, 0));
        vt.push_back(mk(0, 3'b001, 0, 8'h00, 3'd0, 1, 0, 2, 0));
        vt.push_back(mk(0, 3'b010, 0, 8'h00, 3'd0, 2, 0, 2, 0));
        vt.push_back(mk(0, 3'b011, 0, 8'h00, 3'd0, 0, 0, 2, 0));
        vt.push_back(mk(0, 3'b100, 0, 8'h00, 3'd0, 0, 0, 2, 0));
        vt.push_back(mk(0, 3'b100, 1, 8'h4A, 3'd4, 0, 0, 2, 0));
        vt.push_back(mk(0, 3'b100, 0, 8'h00, 3'd0, 1, 0, 2, 0));
        vt.push_back(mk(0, 3'b100, 0, 8'h00, 3'd0, 2, 0, 2, 0));
        vt.push_back(mk(0, 3'b001, 0, 8'h00, 3'd0, 3, 0, 2, 0));
        vt.push_back(mk(0, 3'b010, 0, 8'h00, 3'd0, 0, 1, 3, 0));
        vt.push_back(mk(0, 3'b000, 1, 8'h4A, 3'd1, 0, 0, 3, 1));
        vt.push_back(mk(0, 3'b100, 0, 8'h00, 3'd0, 1, 0, 3, 1));
        vt.push_back(mk(0, 3'b100, 0, 8'h00, 3'd0, 2, 0, 3, 1));
        vt.push_back(mk(0, 3'b001, 0, 8'h00, 3'd0, 3, 0, 3, 1));
        vt.push_back(mk(0, 3'b010, 0, 8'h00, 3'd0, 0, 1, 4, 1));
        vt.push_back(mk(0, 3'b000, 1, 8'h4A, 3'd5, 0, 0, 4, 1));
        vt.push_back(mk(0, 3'b000, 1, 8'h4E, 3'd4, 0, 0, 4, 1));
        vt.push_back(mk(0, 3'b000, 1, 8'hC4, 3'd2, 0, 0, 4, 0));
        vt.push_back(mk(0, 3'b001, 0, 8'h00, 3'd0, 1, 0, 4, 0));
        vt.push_back(mk(0, 3'b010, 0, 8'h00, 3'd0, 0, 1, 5, 0));
        vt.push_back(mk(0, 3'b010, 0, 8'h00, 3'd0, 0, 0, 5, 0));
        vt.push_back(mk(0, 3'b001, 0, 8'h00, 3'd0, 1, 0, 5, 0));
        vt.push_back(mk(0, 3'b001, 0, 8'h00, 3'd0, 1, 0, 5, 0));
        vt.push_back(mk(1, 3'b111, 0, 8'h00, 3'd0, 0, 0, 0, 0));
        vt.push_back(mk(0, 3'b100, 0, 8'h00, 3'd0, 0, 0, 0, 0));

        for (int i = 0; i < vt.size(); i++) begin
            step(vt[i].r, vt[i].l, vt[i].w, vt[i].s, vt[i].n);
            cmp($sformatf("vec%0d_pos", i), int'(pos_a), vt[i].pos);
            cmp($sformatf("vec%0d_alarm", i), int'(alarm_a), vt[i].al);
            cmp($sformatf("vec%0d_cnt", i), int'(cnt_a), vt[i].cnt);
            cmp($sformatf("vec%0d_err", i), int'(err_a), vt[i].err);
        end

        // Idle cycles between events: held by default, abandoned with the timeout.
        step(1, 3'b000, 0, 8'h00, 3'd0);
        ev(3'b001); ev(3'b000); ev(3'b000);
        cmp("idle_pos_after_2_idles", int'(pos_a), IDLE_POS);
        ev(3'b010); ev(3'b000); ev(3'b100);
        cmp("idle_alarm", int'(alarm_a), IDLE_AL);
        cmp("idle_det_cnt", int'(cnt_a), IDLE_CNT);

        // Hold of 4: second detection 3 cycles after the first keeps alarm high.
        step(1, 3'b000, 0, 8'h00, 3'd0);
        ev(3'b001); ev(3'b010); ev(3'b100);
        cmp("hold_first", int'(alarm_b), 1);
        ev(3'b001);
        cmp("hold_a_short", int'(alarm_a), 0);
        cmp("hold_cont1", int'(alarm_b), 1);
        ev(3'b010);
        cmp("hold_cont2", int'(alarm_b), 1);
        ev(3'b100);
        cmp("hold_second", int'(alarm_b), 1);
        cmp("hold_cnt2", int'(cnt_b), 2);
        for (int i = 0; i < 3; i++) begin
            ev(3'b000);
            cmp($sformatf("hold_tail%0d", i), int'(alarm_b), 1);
        end
        ev(3'b000);
        cmp("hold_fall", int'(alarm_b), 0);

        // Saturation of the 2-bit counter, then reset in the middle of a hold.
        step(1, 3'b000, 0, 8'h00, 3'd0);
        for (int d = 0; d < 5; d++) begin
            ev(3'b001); ev(3'b010); ev(3'b100);
        end
        cmp("sat_cnt_b", int'(cnt_b), 3);
        cmp("sat_cnt_a", int'(cnt_a), 5);
        ev(3'b001);
        cmp("pre_reset_alarm_b", int'(alarm_b), 1);
        step(1, 3'b001, 0, 8'h00, 3'd0);
        cmp("rst_alarm_b", int'(alarm_b), 0);
        cmp("rst_cnt_b", int'(cnt_b), 0);
        cmp("rst_pos_b", int'(pos_b), 0);

        // Random traffic biased towards the currently expected lamp.
        for (int t = 0; t < 3000; t++) begin
            c = $urandom_range(0, 99);
            if (c < 55) rl = 3'(1 << m_seq[m_pos]);
            else if (c < 70) rl = 3'(1 << $urandom_range(0, 2));
            else if (c < 85) rl = 3'b000;
            else rl = 3'($urandom);
            c = $urandom_range(0, 999);
            if (c < 3) begin
                step(1, rl, 0, 8'h00, 3'd0);
            end else if (c < 25) begin
                rn = 3'($urandom_range(1, 5));
                rs = 8'($urandom);
                if ($urandom_range(0, 3) != 0) begin
                    for (int i = 0; i < 4; i++)
                        if (rs[2*i +: 2] == 2'd3) rs[2*i +: 2] = 2'($urandom_range(0, 2));
                end
                step(0, rl, 1, rs, rn);
            end else begin
                step(0, rl, 0, 8'h00, 3'd0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
